// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared sizes, frame/entry types and pointer helper for the serial crossbar
//
// Purpose: single source for the crossbar geometry. Everything else derives
// its widths from here, so changing ports/packet_width re-sizes the design.
// Ports: none (package).
package xbar_pkg;

    localparam int ports        = 4;
    localparam int packet_width = 8;
    localparam int DEST_W       = $clog2(ports);
    localparam int SRC_W        = DEST_W;
    localparam int FRAME_BITS   = packet_width + DEST_W;
    localparam int FIFO_DEPTH   = 4;
    localparam int ADDR_W       = $clog2(FIFO_DEPTH);
    localparam int PTR_W        = ADDR_W + 1;
    localparam int CNT_W        = $clog2(FRAME_BITS);

    typedef logic [DEST_W-1:0] port_t;

    // Wire format of one serial frame: destination in the top bits.
    typedef struct packed {
        port_t                   dest;
        logic [packet_width-1:0] payload;
    } frame_t;

    // What each output queue stores: the payload plus where it came from.
    typedef struct packed {
        port_t                   src;
        logic [packet_width-1:0] payload;
    } entry_t;

    // Pointers carry one extra wrap bit: same slot but different wrap = full.
    function automatic logic ptr_full(input logic [PTR_W-1:0] wptr,
                                      input logic [PTR_W-1:0] rptr);
        return (wptr[ADDR_W] != rptr[ADDR_W]) &&
               (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    endfunction

endpackage

// File: rtl/xbar_switch_if.sv
// rtl/xbar_switch_if.sv - serial input and per-port output handshake bundle
//
// Purpose: groups the crossbar's data-path signals.
// Signals:
//   serial_in  - serial frame stream, MSB first
//   ready_in   - per-output consumer ready
//   valid_out  - per-output queue not empty
//   data_out   - per-output head payload
//   src_out    - per-output head source tag
//   overflow   - per-output sticky drop flag
// Modports: slave = the crossbar, master = the driver/consumer side.
interface xbar_switch_if;
    import xbar_pkg::*;

    logic                                   serial_in;
    logic [ports-1:0]                       ready_in;
    logic [ports-1:0]                       valid_out;
    logic [ports-1:0][packet_width-1:0]     data_out;
    logic [ports-1:0][SRC_W-1:0]            src_out;
    logic [ports-1:0]                       overflow;

    modport slave (
        input  serial_in,
        input  ready_in,
        output valid_out,
        output data_out,
        output src_out,
        output overflow
    );

    modport master (
        output serial_in,
        output ready_in,
        input  valid_out,
        input  data_out,
        input  src_out,
        input  overflow
    );

endinterface

// File: rtl/xbar_switch_counter.sv
// rtl/xbar_switch_counter.sv - free-running modulo-MOD counter
//
// Purpose: tracks the bit position inside a serial frame.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset, clears count to 0
//   count - current position, 0..MOD-1, wraps
module counter #(
    parameter int MOD = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [$clog2(MOD)-1:0] count
);

    localparam int W = $clog2(MOD);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_count == W'(MOD - 1)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/xbar_switch.sv
// rtl/xbar_switch.sv - serial-input crossbar with per-destination output queues
//
// Purpose: deserializes 10-bit frames (dest + payload), tags each with a
// source index, and queues it in the FIFO of its destination port.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-low reset
//   bus - xbar_switch_if.slave: serial_in, ready_in, valid_out, data_out,
//         src_out, overflow
module xbar_switch
    import xbar_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    xbar_switch_if.slave  bus
);

    logic [CNT_W-1:0]      w_count;
    logic                  w_last_bit;
    logic [FRAME_BITS-1:0] w_frame_bits;

    // Only FRAME_BITS-1 bits are kept: the final bit goes straight into
    // r_frame together with the accumulated ones.
    logic [FRAME_BITS-2:0] r_shift;
    frame_t                r_frame;
    logic                  r_frame_vld;
    port_t                 r_frame_src;
    port_t                 r_frame_idx;

    counter #(
        .MOD   (FRAME_BITS)
    ) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .count (w_count)
    );

    assign w_last_bit   = (w_count == CNT_W'(FRAME_BITS - 1));
    assign w_frame_bits = {r_shift, bus.serial_in};

    // Frame capture. The source tag is the frame index mod ports; port_t is
    // exactly log2(ports) bits, so natural wrap gives the modulo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_frame     <= '0;
            r_frame_vld <= 1'b0;
            r_frame_src <= '0;
            r_frame_idx <= '0;
        end else begin
            r_shift     <= w_frame_bits[FRAME_BITS-2:0];
            r_frame_vld <= w_last_bit;
            if (w_last_bit) begin
                r_frame     <= frame_t'(w_frame_bits);
                r_frame_src <= r_frame_idx;
                r_frame_idx <= r_frame_idx + port_t'(1);
            end
        end
    end

    for (genvar p = 0; p < ports; p++) begin : g_q
        entry_t           r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic             r_ovf;
        logic             w_empty;
        logic             w_full;
        logic             w_push;
        logic             w_pop;
        logic             w_accept;

        assign w_empty  = (r_wptr == r_rptr);
        assign w_full   = ptr_full(r_wptr, r_rptr);
        assign w_push   = r_frame_vld && (r_frame.dest == port_t'(p));
        assign w_pop    = !w_empty && bus.ready_in[p];
        // A pop in the same cycle frees the head slot, so a full queue can
        // still take the new frame; the write lands in the slot being vacated.
        assign w_accept = w_push && (!w_full || w_pop);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end else begin
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_accept) begin
                    r_mem[r_wptr[ADDR_W-1:0]] <= '{src: r_frame_src, payload: r_frame.payload};
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_push && !w_accept) begin
                    r_ovf <= 1'b1;
                end
            end
        end

        assign bus.valid_out[p] = !w_empty;
        assign bus.data_out[p]  = r_mem[r_rptr[ADDR_W-1:0]].payload;
        assign bus.src_out[p]   = r_mem[r_rptr[ADDR_W-1:0]].src;
        assign bus.overflow[p]  = r_ovf;
    end

endmodule

// File: tb/tb_xbar_switch.sv
// tb/tb_xbar_switch.sv - self-checking bench for xbar_switch
module tb_xbar_switch;
    import xbar_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xbar_switch_if u_if();

    xbar_switch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        logic [1:0] dest;
        logic [7:0] payload;
        bit         drop;
    } tx_t;

    typedef struct {
        logic [1:0] src;
        logic [7:0] payload;
    } exp_t;

    tx_t        tx_q[$];
    exp_t       sb_q[ports][$];
    int         checks;
    int         failures;
    int         frame_no;
    logic [1:0] filler_dest;

    // Serial driver: frames are sent back to back from reset release; when
    // no test frame is pending a filler frame goes to filler_dest.
    initial begin
        int         bit_i;
        logic [9:0] cur;
        bit         cur_drop;
        tx_t        t;
        exp_t       e;
        bit_i = 0;
        cur = '0;
        cur_drop = 1'b0;
        u_if.serial_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bit_i = 0;
                u_if.serial_in = 1'b0;
            end else begin
                if (bit_i == 0) begin
                    if (tx_q.size() > 0) begin
                        t = tx_q.pop_front();
                    end else begin
                        t.dest = filler_dest;
                        t.payload = 8'($urandom);
                        t.drop = 1'b0;
                    end
                    cur = {t.dest, t.payload};
                    cur_drop = t.drop;
                end
                u_if.serial_in = cur[9 - bit_i];
                if (bit_i == 9) begin
                    if (!cur_drop) begin
                        e.src = 2'(frame_no % ports);
                        e.payload = cur[7:0];
                        sb_q[cur[9:8]].push_back(e);
                    end
                    frame_no++;
                    bit_i = 0;
                end else begin
                    bit_i++;
                end
            end
        end
    end

    // Scoreboard: every head the DUT hands out must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int p = 0; p < ports; p++) begin
                if (u_if.valid_out[p] && u_if.ready_in[p]) begin
                    checks++;
                    if (sb_q[p].size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected port=%0d got data=%h src=%0d expected nothing",
                                 p, u_if.data_out[p], u_if.src_out[p]);
                    end else begin
                        e = sb_q[p].pop_front();
                        if (u_if.data_out[p] !== e.payload || u_if.src_out[p] !== e.src) begin
                            failures++;
                            $display("FAIL sb_pop port=%0d got data=%h src=%0d expected data=%h src=%0d",
                                     p, u_if.data_out[p], u_if.src_out[p], e.payload, e.src);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete();
        for (int p = 0; p < ports; p++) sb_q[p].delete();
        frame_no = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        u_if.ready_in = '0;
        filler_dest = 2'd0;
        frame_no = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (u_if.valid_out !== 4'h0) begin failures++; $display("FAIL reset_valid got %h expected 0", u_if.valid_out); end
        checks++;
        if (u_if.overflow !== 4'h0) begin failures++; $display("FAIL reset_overflow got %h expected 0", u_if.overflow); end
        checks++;
        if (u_if.data_out !== '0) begin failures++; $display("FAIL reset_data got %h expected 0", u_if.data_out); end
        checks++;
        if (u_if.src_out !== '0) begin failures++; $display("FAIL reset_src got %h expected 0", u_if.src_out); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        int n;
        u_if.ready_in = 4'hF;
        filler_dest = 2'd0;
        tx_q.push_back('{dest: 2'd2, payload: 8'hA5, drop: 1'b0});
        n = 0;
        while (!u_if.valid_out[2] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 11) begin failures++; $display("FAIL single_latency got %0d edges expected 11", n); end
        checks++;
        if (u_if.data_out[2] !== 8'hA5) begin failures++; $display("FAIL single_data got %h expected a5", u_if.data_out[2]); end
        checks++;
        if (u_if.src_out[2] !== 2'd0) begin failures++; $display("FAIL single_src got %0d expected 0", u_if.src_out[2]); end
        checks++;
        if ((u_if.valid_out & 4'b1011) !== 4'b0000) begin failures++; $display("FAIL single_others got %b expected 0000 on ports 0,1,3", u_if.valid_out); end
        @(posedge clk);
        #1;
        checks++;
        if (u_if.valid_out[2] !== 1'b0) begin failures++; $display("FAIL single_pulse got %b expected 0", u_if.valid_out[2]); end
    endtask

    task automatic test_fifo_order();
        logic [7:0] pl [4];
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        u_if.ready_in = 4'b1101;
        filler_dest = 2'd0;
        for (int k = 0; k < 4; k++) tx_q.push_back('{dest: 2'd1, payload: pl[k], drop: 1'b0});
        repeat (45) @(posedge clk);
        #1;
        checks++;
        if (u_if.overflow[1] !== 1'b0) begin failures++; $display("FAIL order_overflow got %b expected 0", u_if.overflow[1]); end
        u_if.ready_in[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (u_if.valid_out[1] !== 1'b1 || u_if.data_out[1] !== pl[k] || u_if.src_out[1] !== 2'(k)) begin
                failures++;
                $display("FAIL order_head%0d got v=%b data=%h src=%0d expected v=1 data=%h src=%0d",
                         k, u_if.valid_out[1], u_if.data_out[1], u_if.src_out[1], pl[k], k);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (u_if.valid_out[1] !== 1'b0) begin failures++; $display("FAIL order_empty got %b expected 0", u_if.valid_out[1]); end
    endtask

    task automatic test_overflow();
        do_reset();
        u_if.ready_in = 4'b0111;
        filler_dest = 2'd0;
        for (int k = 0; k < 5; k++) tx_q.push_back('{dest: 2'd3, payload: 8'(8'h51 + k), drop: (k == 4)});
        repeat (55) @(posedge clk);
        #1;
        checks++;
        if (u_if.overflow !== 4'b1000) begin failures++; $display("FAIL ovf_flag got %b expected 1000", u_if.overflow); end
        u_if.ready_in = 4'hF;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (u_if.valid_out[3] !== 1'b1 || u_if.data_out[3] !== 8'(8'h51 + k) || u_if.src_out[3] !== 2'(k)) begin
                failures++;
                $display("FAIL ovf_drain%0d got v=%b data=%h src=%0d expected v=1 data=%h src=%0d",
                         k, u_if.valid_out[3], u_if.data_out[3], u_if.src_out[3], 8'(8'h51 + k), k);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (u_if.valid_out[3] !== 1'b0) begin failures++; $display("FAIL ovf_empty got %b expected 0", u_if.valid_out[3]); end
        checks++;
        if (u_if.overflow[3] !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b expected 1", u_if.overflow[3]); end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen_v1;
        do_reset();
        u_if.ready_in = 4'hF;
        filler_dest = 2'd2;
        tx_q.push_back('{dest: 2'd1, payload: 8'hEE, drop: 1'b0});
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        tx_q.push_back('{dest: 2'd0, payload: 8'h3C, drop: 1'b0});
        n = 0;
        seen_v1 = 0;
        while (!u_if.valid_out[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (u_if.valid_out[1]) seen_v1++;
        end
        checks++;
        if (n !== 11) begin failures++; $display("FAIL mid_latency got %0d edges expected 11", n); end
        checks++;
        if (u_if.data_out[0] !== 8'h3C || u_if.src_out[0] !== 2'd0) begin
            failures++;
            $display("FAIL mid_head got data=%h src=%0d expected data=3c src=0", u_if.data_out[0], u_if.src_out[0]);
        end
        checks++;
        if (seen_v1 !== 0) begin failures++; $display("FAIL mid_aborted got %0d valid cycles on port1 expected 0", seen_v1); end
    endtask

    task automatic test_full_pushpop();
        int n;
        logic [7:0] pl [4];
        logic [1:0] sr [4];
        pl = '{8'h62, 8'h63, 8'h64, 8'h65};
        sr = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        u_if.ready_in = 4'b1011;
        filler_dest = 2'd0;
        for (int k = 0; k < 5; k++) tx_q.push_back('{dest: 2'd2, payload: 8'(8'h61 + k), drop: 1'b0});
        n = 0;
        while (frame_no < 5 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (frame_no < 5) begin failures++; $display("FAIL full_wait got %0d frames expected 5", frame_no); end
        // Fifth frame is registered now; it is written on the next edge,
        // the same edge that pops the head of the full queue.
        u_if.ready_in[2] = 1'b1;
        @(posedge clk);
        #1;
        u_if.ready_in[2] = 1'b0;
        checks++;
        if (u_if.overflow[2] !== 1'b0) begin failures++; $display("FAIL full_no_ovf got %b expected 0", u_if.overflow[2]); end
        u_if.ready_in = 4'hF;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (u_if.valid_out[2] !== 1'b1 || u_if.data_out[2] !== pl[k] || u_if.src_out[2] !== sr[k]) begin
                failures++;
                $display("FAIL full_drain%0d got v=%b data=%h src=%0d expected v=1 data=%h src=%0d",
                         k, u_if.valid_out[2], u_if.data_out[2], u_if.src_out[2], pl[k], sr[k]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (u_if.valid_out[2] !== 1'b0) begin failures++; $display("FAIL full_empty got %b expected 0", u_if.valid_out[2]); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_fifo_order();
        test_overflow();
        test_reset_mid();
        test_full_pushpop();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
